// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative data cache: word width, I/O region code,
// FSM state type and PLRU tree encode/decode helpers (supports 1, 2 or 4 ways).
package dcache_pkg;

   localparam int unsigned REG_LEN = 32;
   localparam logic [1:0]  IO_REGION = 2'b11;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   // Point the PLRU state away from the way just accessed.
   function automatic logic [2:0] plru_encode(input int unsigned ways,
                                              input logic [2:0] st,
                                              input logic [1:0] way);
      logic [2:0] n;
      n = st;
      if (ways == 2) begin
         n[0] = ~way[0];
      end else if (ways == 4) begin
         n[0] = ~way[1];
         if (way[1]) n[2] = ~way[0];
         else        n[1] = ~way[0];
      end
      return n;
   endfunction

   // Way the PLRU state currently points at (the least recently used one).
   function automatic logic [1:0] plru_decode(input int unsigned ways,
                                              input logic [2:0] st);
      logic [1:0] w;
      w = 2'd0;
      if (ways == 2)      w = {1'b0, st[0]};
      else if (ways == 4) w = st[0] ? {1'b1, st[2]} : {1'b0, st[1]};
      return w;
   endfunction

endpackage

// File: rtl/dcache_plru.sv
// Per-set pseudo-LRU state and refill victim selection (lowest invalid way first).
module dcache_plru
   import dcache_pkg::*;
#(
   parameter int unsigned WAYS     = 2,
   parameter int unsigned SET_BITS = 7,
   localparam int unsigned WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr_en,
   input  logic [SET_BITS-1:0] clr_idx,
   input  logic                lk_en,
   input  logic [SET_BITS-1:0] lk_idx,
   input  logic [WAY_W-1:0]    lk_way,
   input  logic                st_en,
   input  logic [SET_BITS-1:0] st_idx,
   input  logic [WAY_W-1:0]    st_way,
   input  logic                rp_en,
   input  logic [SET_BITS-1:0] rp_idx,
   input  logic [WAY_W-1:0]    rp_way,
   input  logic [SET_BITS-1:0] vic_idx,
   input  logic [WAYS-1:0]     vic_valid,
   output logic [WAY_W-1:0]    vic_way_c
);

   localparam int unsigned SETS = 1 << SET_BITS;

   logic [2:0] plru_q [SETS];

   always_comb begin
      vic_way_c = WAY_W'(plru_decode(WAYS, plru_q[vic_idx]));
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!vic_valid[w]) vic_way_c = WAY_W'(w);
      end
   end

   // Later updates take priority on a shared set: replace over store over lookup.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned s = 0; s < SETS; s++) plru_q[s] <= '0;
      end else begin
         if (lk_en) plru_q[lk_idx] <= plru_encode(WAYS, plru_q[lk_idx], 2'(lk_way));
         if (st_en) plru_q[st_idx] <= plru_encode(WAYS, plru_q[st_idx], 2'(st_way));
         if (rp_en) plru_q[rp_idx] <= plru_encode(WAYS, plru_q[rp_idx], 2'(rp_way));
         if (clr_en) plru_q[clr_idx] <= '0;
      end
   end

endmodule

// File: rtl/dcache_sa.sv
// Set-associative write-through data cache, one word per line, with sequential flush.
// Define DCACHE_STATS_EN to add stat_hit/stat_miss lookup counters.
module dcache_sa
   import dcache_pkg::*;
#(
   parameter int unsigned WAYS     = 2,
   parameter int unsigned SET_BITS = 7,
   parameter int unsigned TAG_BITS = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic [31:0]        rd_addr,
   output logic               rd_valid,
   output logic               rd_hit,
   output logic [REG_LEN-1:0] rd_data,
   input  logic               replace,
   input  logic [31:0]        rp_addr,
   input  logic [REG_LEN-1:0] rp_data,
   input  logic               rp_valid,
   input  logic               wr_en,
   input  logic [31:0]        wr_addr,
   input  logic [REG_LEN-1:0] wr_data,
   input  logic [3:0]         wr_be,
   input  logic               flush_req,
   output logic               flush_busy
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]        stat_hit,
   output logic [31:0]        stat_miss
`endif
);

   localparam int unsigned SETS  = 1 << SET_BITS;
   localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
   logic [REG_LEN-1:0]  data_q  [SETS][WAYS];
   logic [WAYS-1:0]     valid_q [SETS];

   state_e              state_q, state_d;
   logic [SET_BITS-1:0] flush_cnt_q, flush_cnt_d;
   logic                clr_en_c;

   logic [SET_BITS-1:0] rd_idx, wr_idx, rp_idx;
   logic [TAG_BITS-1:0] rd_tag, wr_tag, rp_tag;
   logic                idle, rd_io, wr_io, rp_io;
   logic                rd_hit_c, wr_hit_c, rp_match_c, st_ok_c, rp_ok_c;
   logic [WAY_W-1:0]    rd_way_c, wr_way_c, rp_mway_c, rp_way_c, vic_way_c;
   logic [REG_LEN-1:0]  rd_word_c, merged_c;
   logic                unused_addr;

   assign rd_idx = rd_addr[SET_BITS+1:2];
   assign wr_idx = wr_addr[SET_BITS+1:2];
   assign rp_idx = rp_addr[SET_BITS+1:2];
   assign rd_tag = rd_addr[SET_BITS+TAG_BITS+1:SET_BITS+2];
   assign wr_tag = wr_addr[SET_BITS+TAG_BITS+1:SET_BITS+2];
   assign rp_tag = rp_addr[SET_BITS+TAG_BITS+1:SET_BITS+2];
   assign rd_io  = (rd_addr[17:16] == IO_REGION);
   assign wr_io  = (wr_addr[17:16] == IO_REGION);
   assign rp_io  = (rp_addr[17:16] == IO_REGION);
   assign idle   = (state_q == ST_IDLE);
   assign unused_addr = ^{rd_addr, wr_addr, rp_addr};

   // Tag match on each request's set, using array state from before the edge.
   always_comb begin
      rd_hit_c   = 1'b0;
      wr_hit_c   = 1'b0;
      rp_match_c = 1'b0;
      rd_way_c   = '0;
      wr_way_c   = '0;
      rp_mway_c  = '0;
      rd_word_c  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[rd_idx][w] && tag_q[rd_idx][w] == rd_tag) begin
            rd_hit_c  = 1'b1;
            rd_way_c  = WAY_W'(w);
            rd_word_c = data_q[rd_idx][w];
         end
         if (valid_q[wr_idx][w] && tag_q[wr_idx][w] == wr_tag) begin
            wr_hit_c = 1'b1;
            wr_way_c = WAY_W'(w);
         end
         if (valid_q[rp_idx][w] && tag_q[rp_idx][w] == rp_tag) begin
            rp_match_c = 1'b1;
            rp_mway_c  = WAY_W'(w);
         end
      end
      if (!rd_en || rd_io || !idle) rd_hit_c = 1'b0;
   end

   assign rp_ok_c  = replace && !rp_io && idle;
   assign rp_way_c = rp_match_c ? rp_mway_c : vic_way_c;
   // A refill landing on the store's line (or evicting it) discards the store.
   assign st_ok_c  = wr_en && !wr_io && idle && wr_hit_c &&
                     !(rp_ok_c && rp_idx == wr_idx && rp_way_c == wr_way_c);

   always_comb begin
      merged_c = data_q[wr_idx][wr_way_c];
      for (int b = 0; b < 4; b++) begin
         if (wr_be[b]) merged_c[8*b +: 8] = wr_data[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      clr_en_c    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (flush_req) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = '0;
            end
         end
         ST_FLUSH: begin
            clr_en_c    = 1'b1;
            flush_cnt_d = flush_cnt_q + 1'b1;
            if (&flush_cnt_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
         rd_valid   <= 1'b0;
         rd_hit     <= 1'b0;
         rd_data    <= '0;
         flush_busy <= 1'b0;
      end else begin
         rd_valid   <= rd_en;
         rd_hit     <= rd_hit_c;
         rd_data    <= rd_hit_c ? rd_word_c : '0;
         flush_busy <= (state_d == ST_FLUSH);
         if (rp_ok_c)  valid_q[rp_idx][rp_way_c] <= rp_valid;
         if (clr_en_c) valid_q[flush_cnt_q] <= '0;
      end
   end

   // Tag and data arrays carry no reset; validity lives in valid_q.
   always_ff @(posedge clk) begin
      if (st_ok_c) data_q[wr_idx][wr_way_c] <= merged_c;
      if (rp_ok_c) begin
         tag_q[rp_idx][rp_way_c]  <= rp_tag;
         data_q[rp_idx][rp_way_c] <= rp_data;
      end
   end

   dcache_plru #(
      .WAYS     (WAYS),
      .SET_BITS (SET_BITS)
   ) u_plru (
      .clk       (clk),
      .rst       (rst),
      .clr_en    (clr_en_c),
      .clr_idx   (flush_cnt_q),
      .lk_en     (rd_hit_c),
      .lk_idx    (rd_idx),
      .lk_way    (rd_way_c),
      .st_en     (st_ok_c),
      .st_idx    (wr_idx),
      .st_way    (wr_way_c),
      .rp_en     (rp_ok_c),
      .rp_idx    (rp_idx),
      .rp_way    (rp_way_c),
      .vic_idx   (rp_idx),
      .vic_valid (valid_q[rp_idx]),
      .vic_way_c (vic_way_c)
   );

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_hit  <= '0;
         stat_miss <= '0;
      end else if (rd_en) begin
         if (rd_hit_c) stat_hit  <= stat_hit + 32'd1;
         else          stat_miss <= stat_miss + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_sa.sv
// Directed self-checking bench for dcache_sa (2 ways, 128 sets, 16-bit tags).
module tb_dcache_sa;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en;
   logic [31:0] rd_addr;
   logic        rd_valid, rd_hit;
   logic [31:0] rd_data;
   logic        replace;
   logic [31:0] rp_addr, rp_data;
   logic        rp_valid;
   logic        wr_en;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_be;
   logic        flush_req, flush_busy;
`ifdef DCACHE_STATS_EN
   logic [31:0] stat_hit, stat_miss;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // Tag covers addr[24:9] so bits 17/18 distinguish lines in the same set.
   dcache_sa #(.WAYS(2), .SET_BITS(7), .TAG_BITS(16)) dut (
      .clk(clk), .rst(rst),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_data(rd_data),
      .replace(replace), .rp_addr(rp_addr), .rp_data(rp_data), .rp_valid(rp_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .flush_req(flush_req), .flush_busy(flush_busy)
`ifdef DCACHE_STATS_EN
      , .stat_hit(stat_hit), .stat_miss(stat_miss)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input logic [31:0] a, output logic v, output logic h,
                         output logic [31:0] d);
      rd_en = 1'b1; rd_addr = a;
      tick();
      v = rd_valid; h = rd_hit; d = rd_data;
      rd_en = 1'b0;
   endtask

   task automatic refill(input logic [31:0] a, input logic [31:0] d);
      replace = 1'b1; rp_addr = a; rp_data = d; rp_valid = 1'b1;
      tick();
      replace = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      logic v, h; logic [31:0] d;
      rst = 1'b1;
      tick(); tick();
      n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
      n_cmp++; if (rd_hit !== 1'b0) begin n_bad++; $display("FAIL reset_rd_hit got %b exp 0", rd_hit); end
      n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
      n_cmp++; if (flush_busy !== 1'b0) begin n_bad++; $display("FAIL reset_flush_busy got %b exp 0", flush_busy); end
      rst = 1'b0;
      tick();
      n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL idle_rd_valid got %b exp 0", rd_valid); end
      lookup(32'h0000_0100, v, h, d);
      n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL cold_valid got %b exp 1", v); end
      n_cmp++; if (h !== 1'b0) begin n_bad++; $display("FAIL cold_hit got %b exp 0", h); end
   endtask

   task automatic test_refill();
      logic v, h; logic [31:0] d;
      refill(32'h0000_0100, 32'hDEAD_BEEF);
      lookup(32'h0000_0100, v, h, d);
      n_cmp++; if (h !== 1'b1) begin n_bad++; $display("FAIL refill_hit got %b exp 1", h); end
      n_cmp++; if (d !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL refill_data got %h exp deadbeef", d); end
   endtask

   task automatic test_store();
      logic v, h; logic [31:0] d;
      store(32'h0000_0100, 32'h1122_3344, 4'b0011);
      lookup(32'h0000_0100, v, h, d);
      n_cmp++; if (d !== 32'hDEAD_3344 || h !== 1'b1) begin n_bad++; $display("FAIL store_merge got %b/%h exp 1/dead3344", h, d); end
      store(32'h0000_0200, 32'hAAAA_AAAA, 4'b1111);
      lookup(32'h0000_0200, v, h, d);
      n_cmp++; if (h !== 1'b0) begin n_bad++; $display("FAIL store_no_alloc got %b exp 0", h); end
   endtask

   task automatic test_same_cycle();
      logic v, h; logic [31:0] d;
      // Lookup concurrent with a refill of the same line sees the old word.
      rd_en = 1'b1; rd_addr = 32'h0000_0100;
      replace = 1'b1; rp_addr = 32'h0000_0100; rp_data = 32'hCAFE_F00D; rp_valid = 1'b1;
      tick();
      rd_en = 1'b0; replace = 1'b0;
      n_cmp++; if (rd_data !== 32'hDEAD_3344) begin n_bad++; $display("FAIL same_cycle_old got %h exp dead3344", rd_data); end
      lookup(32'h0000_0100, v, h, d);
      n_cmp++; if (d !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL same_cycle_new got %h exp cafef00d", d); end
      // Refill and store to the same line: refill data wins.
      wr_en = 1'b1; wr_addr = 32'h0000_0100; wr_data = 32'hFFFF_FFFF; wr_be = 4'b1111;
      replace = 1'b1; rp_addr = 32'h0000_0100; rp_data = 32'h1234_5678; rp_valid = 1'b1;
      tick();
      wr_en = 1'b0; replace = 1'b0;
      lookup(32'h0000_0100, v, h, d);
      n_cmp++; if (d !== 32'h1234_5678) begin n_bad++; $display("FAIL rp_beats_wr got %h exp 12345678", d); end
   endtask

   task automatic test_plru();
      logic v, h; logic [31:0] d;
      refill(32'h0002_0100, 32'h0000_000B);
      lookup(32'h0000_0100, v, h, d);
      refill(32'h0004_0100, 32'h0000_000C);
      lookup(32'h0002_0100, v, h, d);
      n_cmp++; if (h !== 1'b0) begin n_bad++; $display("FAIL plru_evicted got %b exp 0", h); end
      lookup(32'h0000_0100, v, h, d);
      n_cmp++; if (h !== 1'b1 || d !== 32'h1234_5678) begin n_bad++; $display("FAIL plru_keep_a got %b/%h exp 1/12345678", h, d); end
      lookup(32'h0004_0100, v, h, d);
      n_cmp++; if (h !== 1'b1 || d !== 32'h0000_000C) begin n_bad++; $display("FAIL plru_keep_c got %b/%h exp 1/0000000c", h, d); end
      // Re-filling a resident tag overwrites in place; PLRU now points at way 0.
      refill(32'h0004_0100, 32'h0000_000D);
      lookup(32'h0000_0100, v, h, d);
      n_cmp++; if (h !== 1'b1) begin n_bad++; $display("FAIL no_dup_a got %b exp 1", h); end
      lookup(32'h0004_0100, v, h, d);
      n_cmp++; if (h !== 1'b1 || d !== 32'h0000_000D) begin n_bad++; $display("FAIL no_dup_c got %b/%h exp 1/0000000d", h, d); end
   endtask

   task automatic test_io();
      logic v, h; logic [31:0] d;
      refill(32'h0003_0100, 32'h0000_0077);
      lookup(32'h0003_0100, v, h, d);
      n_cmp++; if (v !== 1'b1 || h !== 1'b0) begin n_bad++; $display("FAIL io_miss got %b/%b exp 1/0", v, h); end
      lookup(32'h0000_0100, v, h, d);
      n_cmp++; if (h !== 1'b1) begin n_bad++; $display("FAIL io_no_evict got %b exp 1", h); end
   endtask

   task automatic test_flush();
      logic v, h; logic [31:0] d;
      int cnt;
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      cnt = 0;
      while (flush_busy === 1'b1 && cnt < 1000) begin
         cnt++;
         tick();
      end
      n_cmp++; if (cnt !== 128) begin n_bad++; $display("FAIL flush_cycles got %0d exp 128", cnt); end
      lookup(32'h0000_0100, v, h, d);
      n_cmp++; if (h !== 1'b0) begin n_bad++; $display("FAIL flush_a got %b exp 0", h); end
      lookup(32'h0004_0100, v, h, d);
      n_cmp++; if (h !== 1'b0) begin n_bad++; $display("FAIL flush_c got %b exp 0", h); end
   endtask

   task automatic test_reset_mid_flush();
      logic v, h; logic [31:0] d;
      refill(32'h0000_0100, 32'h5555_AAAA);
      lookup(32'h0000_0100, v, h, d);
      n_cmp++; if (h !== 1'b1) begin n_bad++; $display("FAIL preflush_hit got %b exp 1", h); end
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      n_cmp++; if (flush_busy !== 1'b1) begin n_bad++; $display("FAIL mid_flush_busy got %b exp 1", flush_busy); end
      lookup(32'h0000_0100, v, h, d);
      n_cmp++; if (v !== 1'b1 || h !== 1'b0) begin n_bad++; $display("FAIL flush_forced_miss got %b/%b exp 1/0", v, h); end
      rst = 1'b1;
      tick();
      n_cmp++; if (flush_busy !== 1'b0) begin n_bad++; $display("FAIL rst_flush_busy got %b exp 0", flush_busy); end
      rst = 1'b0;
      tick();
      n_cmp++; if (flush_busy !== 1'b0) begin n_bad++; $display("FAIL post_rst_busy got %b exp 0", flush_busy); end
      lookup(32'h0000_0100, v, h, d);
      n_cmp++; if (v !== 1'b1 || h !== 1'b0) begin n_bad++; $display("FAIL post_rst_miss got %b/%b exp 1/0", v, h); end
   endtask

   initial begin
      rst = 1'b1; rd_en = 1'b0; rd_addr = '0;
      replace = 1'b0; rp_addr = '0; rp_data = '0; rp_valid = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
      flush_req = 1'b0;
      test_reset();
      test_refill();
      test_store();
      test_same_cycle();
      test_plru();
      test_io();
      test_flush();
      test_reset_mid_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
